// File: rtl/branch_target_buffer.sv
// Direct-mapped, tagged branch target buffer with a one-entry registered write stage.
// Define BTB_BYPASS_EN to let lookups hit on the pending write before it commits.
module branch_target_buffer #(
    parameter int unsigned N        = 3,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned BTB_SZ   = 32,
    parameter int unsigned TAG_BITS = 10
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [N-1:0][ADDR_W-1:0]    PCs_in,
    output logic [N-1:0]                btb_hits,
    output logic [N-1:0][ADDR_W-1:0]    targets,
    input  logic                        update_valid,
    input  logic [ADDR_W-1:0]           update_pc,
    input  logic [ADDR_W-1:0]           update_target,
    input  logic                        update_taken,
    input  logic                        btb_flush
);

    localparam int unsigned IDX_BITS = $clog2(BTB_SZ);
    localparam int unsigned TAG_LO   = IDX_BITS + 2;
    localparam int unsigned TAG_HI   = TAG_BITS + IDX_BITS + 1;

    logic [BTB_SZ-1:0]   valid_q;
    logic [TAG_BITS-1:0] tag_q    [BTB_SZ];
    logic [ADDR_W-1:0]   target_q [BTB_SZ];

    logic                pend_valid_q;
    logic [IDX_BITS-1:0] pend_idx_q;
    logic [TAG_BITS-1:0] pend_tag_q;
    logic [ADDR_W-1:0]   pend_target_q;

    logic capture;
    assign capture = update_valid && update_taken;

    // Low offset bits and bits above the tag take no part in indexing or matching.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{PCs_in, update_pc};

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q      <= '0;
            pend_valid_q <= 1'b0;
        end else if (btb_flush) begin
            valid_q      <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            if (pend_valid_q) begin
                valid_q[pend_idx_q]  <= 1'b1;
                tag_q[pend_idx_q]    <= pend_tag_q;
                target_q[pend_idx_q] <= pend_target_q;
            end
            pend_valid_q <= capture;
            if (capture) begin
                pend_idx_q    <= update_pc[IDX_BITS+1:2];
                pend_tag_q    <= update_pc[TAG_HI:TAG_LO];
                pend_target_q <= update_target;
            end
        end
    end

    logic [IDX_BITS-1:0] look_idx;
    logic [TAG_BITS-1:0] look_tag;

    always_comb begin
        btb_hits = '0;
        targets  = '0;
        look_idx = '0;
        look_tag = '0;
        for (int i = 0; i < int'(N); i++) begin
            look_idx = PCs_in[i][IDX_BITS+1:2];
            look_tag = PCs_in[i][TAG_HI:TAG_LO];
            btb_hits[i] = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
            targets[i]  = btb_hits[i] ? target_q[look_idx] : '0;
`ifdef BTB_BYPASS_EN
            // A pending write to this index is about to evict; only its own tag may hit.
            if (pend_valid_q && (pend_idx_q == look_idx)) begin
                btb_hits[i] = (pend_tag_q == look_tag);
                targets[i]  = btb_hits[i] ? pend_target_q : '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: driver queues expected lookups, a negedge
// monitor pops and compares. Expectations follow BTB_BYPASS_EN when defined.
module tb_branch_target_buffer;

    localparam int unsigned N      = 3;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned BTB_SZ = 32;
`ifdef BTB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                     clock;
    logic                     reset;
    logic [N-1:0][ADDR_W-1:0] PCs_in;
    logic [N-1:0]             btb_hits;
    logic [N-1:0][ADDR_W-1:0] targets;
    logic                     update_valid;
    logic [ADDR_W-1:0]        update_pc;
    logic [ADDR_W-1:0]        update_target;
    logic                     update_taken;
    logic                     btb_flush;

    branch_target_buffer #(
        .N        (N),
        .ADDR_W   (ADDR_W),
        .BTB_SZ   (BTB_SZ),
        .TAG_BITS (10)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .PCs_in        (PCs_in),
        .btb_hits      (btb_hits),
        .targets       (targets),
        .update_valid  (update_valid),
        .update_pc     (update_pc),
        .update_target (update_target),
        .update_taken  (update_taken),
        .btb_flush     (btb_flush)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string                    name;
        logic [N-1:0]             hits;
        logic [N-1:0][ADDR_W-1:0] tgts;
    } exp_t;

    exp_t exp_q[$];
    logic chk_valid;
    int   n_checks;
    int   n_fails;

    always @(negedge clock) begin
        if (chk_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fails++;
                $display("FAIL scoreboard_underflow: got lookup, required queued expectation");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (btb_hits !== e.hits) begin
                    n_fails++;
                    $display("FAIL %s hits: got %b required %b", e.name, btb_hits, e.hits);
                end
                for (int i = 0; i < int'(N); i++) begin
                    n_checks++;
                    if (targets[i] !== e.tgts[i]) begin
                        n_fails++;
                        $display("FAIL %s target[%0d]: got %h required %h",
                                 e.name, i, targets[i], e.tgts[i]);
                    end
                end
            end
        end
    end

    // One cycle: apply inputs, queue expected lookup result, advance past the next posedge.
    task automatic cyc(input string name,
                       input logic [ADDR_W-1:0] p0, input logic [ADDR_W-1:0] p1,
                       input logic [ADDR_W-1:0] p2, input logic [N-1:0] eh,
                       input logic [ADDR_W-1:0] t0, input logic [ADDR_W-1:0] t1,
                       input logic [ADDR_W-1:0] t2,
                       input logic uv, input logic [ADDR_W-1:0] upc,
                       input logic [ADDR_W-1:0] utgt, input logic ut,
                       input logic fl, input logic chk);
        exp_t e;
        PCs_in[0]     = p0;
        PCs_in[1]     = p1;
        PCs_in[2]     = p2;
        update_valid  = uv;
        update_pc     = upc;
        update_target = utgt;
        update_taken  = ut;
        btb_flush     = fl;
        chk_valid     = chk;
        if (chk) begin
            e.name    = name;
            e.hits    = eh;
            e.tgts[0] = t0;
            e.tgts[1] = t1;
            e.tgts[2] = t2;
            exp_q.push_back(e);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        chk_valid = 1'b0;
        reset = 1'b1;
        PCs_in = '0;
        update_valid = 1'b0;
        update_pc = '0;
        update_target = '0;
        update_taken = 1'b0;
        btb_flush = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // name, pcs, exp hits, exp targets, upd_v, upd_pc, upd_tgt, taken, flush, check
        cyc("reset_lookup", 'h100, 'h104, 'h108, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc("upd_cyc0",     'h100, 'h104, 'h108, 3'b000, 0, 0, 0, 1, 'h100, 'h200, 1, 0, 1);
        cyc("upd_cyc1",     'h100, 'h104, 'h108, BYP ? 3'b001 : 3'b000,
            BYP ? 'h200 : 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc("upd_cyc2",     'h100, 'h104, 'h108, 3'b001, 'h200, 0, 0, 0, 0, 0, 0, 0, 1);

        // Not-taken resolve must not disturb the entry
        cyc("nt_cyc0", 'h100, 'h104, 'h108, 3'b001, 'h200, 0, 0, 1, 'h100, 'h999, 0, 0, 1);
        cyc("nt_cyc1", 'h100, 'h104, 'h108, 3'b001, 'h200, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc("nt_cyc2", 'h100, 'h104, 'h108, 3'b001, 'h200, 0, 0, 0, 0, 0, 0, 0, 1);

        // Alias: 0x180 shares index 0 with 0x100, different tag
        cyc("alias_cyc0", 'h100, 'h180, 'h104, 3'b001, 'h200, 0, 0,
            1, 'h100 + 4 * BTB_SZ, 'h300, 1, 0, 1);
        cyc("alias_cyc1", 'h100, 'h180, 'h104, BYP ? 3'b010 : 3'b001,
            BYP ? 0 : 'h200, BYP ? 'h300 : 0, 0, 0, 0, 0, 0, 0, 1);
        cyc("alias_cyc2", 'h100, 'h180, 'h104, 3'b010, 0, 'h300, 0, 0, 0, 0, 0, 0, 1);

        // Back-to-back updates
        cyc("b2b_cyc0", 'h110, 'h114, 'h180, 3'b100, 0, 0, 'h300, 1, 'h110, 'h400, 1, 0, 1);
        cyc("b2b_cyc1", 'h110, 'h114, 'h180, BYP ? 3'b101 : 3'b100,
            BYP ? 'h400 : 0, 0, 'h300, 1, 'h114, 'h500, 1, 0, 1);
        cyc("b2b_cyc2", 'h110, 'h114, 'h180, BYP ? 3'b111 : 3'b101,
            'h400, BYP ? 'h500 : 0, 'h300, 0, 0, 0, 0, 0, 1);
        cyc("b2b_cyc3", 'h110, 'h114, 'h180, 3'b111, 'h400, 'h500, 'h300, 0, 0, 0, 0, 0, 1);
        cyc("same_idx", 'h110, 'h110, 'h110, 3'b111, 'h400, 'h400, 'h400, 0, 0, 0, 0, 0, 1);

        // Flush against a pending commit and a same-cycle update
        cyc("fl_cyc0", 'h120, 'h124, 'h110, 3'b100, 0, 0, 'h400, 1, 'h120, 'h600, 1, 0, 1);
        cyc("fl_cyc1", 'h120, 'h124, 'h110, BYP ? 3'b101 : 3'b100,
            BYP ? 'h600 : 0, 0, 'h400, 1, 'h124, 'h700, 1, 1, 1);
        cyc("fl_cyc2", 'h120, 'h124, 'h110, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc("fl_cyc3", 'h120, 'h124, 'h100, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Reset while an update is pending discards it
        cyc("rst_cyc0", 'h130, 'h100, 'h104, 3'b000, 0, 0, 0, 1, 'h130, 'h800, 1, 0, 1);
        reset = 1'b1;
        cyc("rst_hold", 'h130, 'h100, 'h104, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        cyc("rst_cyc1", 'h130, 'h100, 'h104, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc("rst_cyc2", 'h130, 'h100, 'h104, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        chk_valid = 1'b0;
        repeat (2) @(posedge clock);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
